multiplier: RTL

Sequential shift-add multiply-accumulate block. It computes x = a*y + b, which reconstructs a dividend from its quotient, divisor and remainder. It is the inverse companion of the repeated-subtraction divider and sits beside it in the arithmetic datapath. It uses a start/done handshake and a fixed latency, and flags results that do not fit in WIDTH bits.

---
 rtl/multiplier_pkg.sv | 6 +
 rtl/multiplier.sv | 70 +++++++
 2 files changed

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared arithmetic-datapath types (multiplier and divider state encodings) and default width.
package multiplier_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, LOAD, MULT, DONE} mul_state_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_LOAD, DIV_SUB, DIV_DONE} div_state_e;
endpackage

// File: rtl/multiplier.sv
// multiplier: sequential shift-add x = a*y + b with start/done handshake and overflow flag.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mreg_q, mreg_d, x_q, x_d;
  logic [2*WIDTH-1:0] dreg_q, dreg_d, acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic               last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mreg_q  <= '0;
      dreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mreg_q  <= mreg_d;
      dreg_q  <= dreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      ovf_q   <= ovf_d;
    end
  end
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? LOAD : IDLE) :
              (state_q == LOAD) ? MULT :
              (state_q == MULT) ? (last ? DONE : MULT) : IDLE;
  end
  // acc holds at most 2^(2W)-2^W, so the 2W-bit add never carries out
  always_comb begin
    mreg_d = (state_q == LOAD) ? a : (state_q == MULT) ? mreg_q >> 1 : mreg_q;
    dreg_d = (state_q == LOAD) ? {{WIDTH{1'b0}}, y} : (state_q == MULT) ? dreg_q << 1 : dreg_q;
    acc_d  = (state_q == LOAD) ? {{WIDTH{1'b0}}, b} :
             (state_q == MULT && mreg_q[0]) ? acc_q + dreg_q : acc_q;
    cnt_d  = (state_q == LOAD) ? '0 : (state_q == MULT) ? cnt_q + CW'(1) : cnt_q;
    busy_d = state_d != IDLE;
    done_d = state_q == DONE;
    x_d    = (state_q == DONE) ? acc_q[WIDTH-1:0] : x_q;
    ovf_d  = (state_q == DONE) ? |acc_q[2*WIDTH-1:WIDTH] : ovf_q;
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign x        = x_q;
  assign overflow = ovf_q;
endmodule
